oam_dma_controller: RTL and testbench



---
 rtl/oam_dma_controller.sv | 119 +++++++++++
 tb/tb_oam_dma_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA sequencer: a CPU write to the trigger address latches a source
// page, halts the CPU, aligns to an even cycle, then moves TRANSFER_LEN bytes
// from {page, index} into PPU OAM as alternating read/write cycles.
module oam_dma_controller #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter int unsigned TRANSFER_LEN = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DATA_OUT,
   input  logic        CPU_RW_n,
   input  logic [7:0]  BUS_DATA_IN,
   output logic        CPU_HALT,
   output logic        DMA_BUS_REQ,
   output logic [15:0] DMA_ADDR,
   output logic        DMA_rden,
   output logic        DMA_write,
   output logic [7:0]  DMA_address,
   output logic [7:0]  DMA_data,
   output logic        DMA_active,
   output logic        DMA_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LEN - 1);

   state_t     state_q;
   logic [7:0] page_q;
   logic [7:0] index_q;
   logic [7:0] index_d;
   logic [7:0] data_q;
   logic       parity_q;
   logic       trigger;
   logic       last_index;

   assign trigger    = (CPU_RW_n == 1'b0) && (CPU_ADDR == TRIGGER_ADDR);
   assign last_index = (index_q == LAST_INDEX);
   // Index wraps to 0 after the last byte; it is 8 bits so it never carries into the page.
   assign index_d    = last_index ? 8'd0 : index_q + 8'd1;

   // Transfer sequencer, cycle parity and captured read data; frozen while ENABLE is low.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         page_q   <= 8'd0;
         index_q  <= 8'd0;
         data_q   <= 8'd0;
         parity_q <= 1'b0;
      end else if (ENABLE) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         parity_q <= ~parity_q;
         case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  page_q  <= CPU_DATA_OUT;
                  state_q <= S_HALT;
               end
            end
            // Odd parity here means the next cycle is even, so the first read can start there.
            S_HALT:  state_q <= parity_q ? S_READ : S_ALIGN;
            S_ALIGN: state_q <= S_READ;
            S_READ: begin
               data_q  <= BUS_DATA_IN;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               index_q <= index_d;
               state_q <= last_index ? S_IDLE : S_READ;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output decode from the registered state; strobes are suppressed while frozen.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      CPU_HALT    = 1'b0;
      DMA_active  = 1'b0;
      DMA_BUS_REQ = 1'b0;
      DMA_ADDR    = 16'h0000;
      DMA_rden    = 1'b0;
      DMA_write   = 1'b0;
      DMA_address = 8'd0;
      DMA_data    = 8'd0;
      DMA_done    = 1'b0;
      if (state_q != S_IDLE) begin
         CPU_HALT   = 1'b1;
         DMA_active = 1'b1;
      end
      case (state_q)
         S_ALIGN: DMA_ADDR = {page_q, index_q};
         S_READ: begin
            DMA_BUS_REQ = 1'b1;
            DMA_ADDR    = {page_q, index_q};
            DMA_rden    = ENABLE;
         end
         S_WRITE: begin
            DMA_BUS_REQ = 1'b1;
            DMA_ADDR    = {page_q, index_q};
            DMA_write   = ENABLE;
            DMA_address = index_q;
            DMA_data    = data_q;
            DMA_done    = ENABLE && last_index;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: random memory contents, random
// pages, gaps and stall position, compared against a transfer-level model.
module tb_oam_dma_controller;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ENABLE = 1'b1;
   logic [15:0] CPU_ADDR = 16'h0000;
   logic [7:0]  CPU_DATA_OUT = 8'h00;
   logic        CPU_RW_n = 1'b1;
   logic [7:0]  BUS_DATA_IN = 8'h00;
   logic        CPU_HALT, DMA_BUS_REQ, DMA_rden, DMA_write, DMA_active, DMA_done;
   logic [15:0] DMA_ADDR;
   logic [7:0]  DMA_address, DMA_data;

   always #5 CLK = ~CLK;

   oam_dma_controller dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .CPU_ADDR(CPU_ADDR), .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n),
      .BUS_DATA_IN(BUS_DATA_IN),
      .CPU_HALT(CPU_HALT), .DMA_BUS_REQ(DMA_BUS_REQ), .DMA_ADDR(DMA_ADDR),
      .DMA_rden(DMA_rden), .DMA_write(DMA_write), .DMA_address(DMA_address),
      .DMA_data(DMA_data), .DMA_active(DMA_active), .DMA_done(DMA_done)
   );

   // Source memory: returns the addressed byte before the end of a read cycle, garbage otherwise.
   logic [7:0] ram [0:65535];
   always @(negedge CLK) BUS_DATA_IN = DMA_rden ? ram[DMA_ADDR] : 8'($urandom);

   // Count of enabled clock edges since reset: its LSB is the cycle parity.
   int unsigned en_edges;
   always @(posedge CLK or posedge RESET)
      if (RESET) en_edges <= 0;
      else if (ENABLE) en_edges <= en_edges + 1;

   // Bus monitor: logs every read and OAM write and counts cycle-level events.
   logic [15:0] rd_q[$];
   logic [15:0] wr_q[$];
   int act_cnt = 0, noreq_cnt = 0, done_cnt = 0, done_bad = 0, strobe_bad = 0, halt_bad = 0;
   always @(negedge CLK) begin
      if (!RESET) begin
         if (DMA_active) act_cnt++;
         if (DMA_active && !DMA_BUS_REQ) noreq_cnt++;
         if (CPU_HALT !== DMA_active) halt_bad++;
         if (DMA_rden) rd_q.push_back(DMA_ADDR);
         if (DMA_write) wr_q.push_back({DMA_address, DMA_data});
         if (DMA_done) begin
            done_cnt++;
            if (!(DMA_write && DMA_address == 8'hFF)) done_bad++;
         end
         if (!ENABLE && (DMA_rden || DMA_write || DMA_done)) strobe_bad++;
      end
   end

   int n_checks = 0;
   int n_fail = 0;
   int rd0, wr0, act0, noreq0, done0, dbad0, sbad0, hbad0;
   int align;
   logic [7:0] exp_page;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({CPU_HALT, DMA_BUS_REQ, DMA_ADDR, DMA_rden, DMA_write,
                  DMA_address, DMA_data, DMA_active, DMA_done});
   endfunction

   // Issue a one-cycle CPU write of 'page' to the trigger address; want_par < 0 accepts any parity.
   task automatic trigger_xfer(input logic [7:0] page, input int want_par);
      if (want_par >= 0 && int'(en_edges % 2) != want_par) tick();
      rd0 = rd_q.size(); wr0 = wr_q.size(); act0 = act_cnt; noreq0 = noreq_cnt;
      done0 = done_cnt; dbad0 = done_bad; sbad0 = strobe_bad; hbad0 = halt_bad;
      // Odd parity at HALT means even parity on the trigger cycle; odd trigger parity needs ALIGN.
      align = int'(en_edges % 2);
      exp_page = page;
      CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = page;
      tick();
      CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h00;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (DMA_active && n < 1500) begin tick(); n++; end
      check({tag, ".ends"}, 64'(DMA_active), 64'd0);
   endtask

   task automatic wait_read(input string tag, input logic [15:0] addr);
      int n = 0;
      while (!(DMA_rden && DMA_ADDR === addr) && n < 1500) begin tick(); n++; end
      check({tag, ".reach"}, 64'(DMA_rden && DMA_ADDR === addr), 64'd1);
   endtask

   // Compare one whole transfer against the model: {page,i} read for i = 0..255 in order,
   // each byte written to OAM[i], one done pulse, 1 + align + 512 (+ stall) active cycles.
   task automatic check_xfer(input string tag, input int extra);
      int errs = 0;
      int nr = rd_q.size() - rd0;
      int nw = wr_q.size() - wr0;
      check({tag, ".active"}, 64'(act_cnt - act0), 64'(513 + align + extra));
      check({tag, ".noreq"}, 64'(noreq_cnt - noreq0), 64'(1 + align));
      check({tag, ".reads"}, 64'(nr), 64'd256);
      if (nr > 0) begin
         check({tag, ".first_rd"}, 64'(rd_q[rd0]), 64'({exp_page, 8'h00}));
         check({tag, ".last_rd"}, 64'(rd_q[rd0 + nr - 1]), 64'({exp_page, 8'hFF}));
      end
      check({tag, ".writes"}, 64'(nw), 64'd256);
      for (int i = 0; i < nw; i++)
         if (wr_q[wr0 + i] !== {8'(i), ram[{exp_page, 8'(i)}]}) errs++;
      check({tag, ".oam_errs"}, 64'(errs), 64'd0);
      check({tag, ".done"}, 64'(done_cnt - done0), 64'd1);
      check({tag, ".done_pos"}, 64'(done_bad - dbad0), 64'd0);
      check({tag, ".strobes"}, 64'(strobe_bad - sbad0 + halt_bad - hbad0), 64'd0);
   endtask

   initial begin
      int k, a, frz_bad;
      logic [7:0] rpage;

      for (int i = 0; i < 65536; i++) ram[16'(i)] = 8'($urandom);
      for (int i = 0; i < 256; i++) ram[16'(16'h0200 + i)] = 8'(i) ^ 8'hA5;

      // Reset state
      repeat (3) tick();
      check("reset.outputs", all_outputs(), 64'd0);
      RESET = 1'b0;
      repeat (2) tick();
      check("idle.outputs", all_outputs(), 64'd0);

      // Page $02, parity 1 at HALT: no ALIGN, 513 active cycles, data i^$A5
      repeat ($urandom_range(1, 6)) tick();
      trigger_xfer(8'h02, 0);
      wait_idle("p1");
      check_xfer("p1", 0);

      // Random page, parity 0 at HALT: one ALIGN; a trigger on the done cycle is ignored
      repeat ($urandom_range(1, 6)) tick();
      rpage = 8'($urandom_range(4, 254));
      trigger_xfer(rpage, 1);
      a = 0;
      while (!DMA_done && a < 1500) begin tick(); a++; end
      CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'h09;
      tick();
      CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h00;
      check("p0.trig_on_done", 64'(DMA_active), 64'd0);
      check_xfer("p0", 0);

      // Second trigger write mid-transfer is ignored; $4015 write and $4014 read never start one
      repeat ($urandom_range(1, 6)) tick();
      trigger_xfer(8'h02, -1);
      wait_read("retrig", 16'h0232);
      CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'h07;
      tick();
      CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h00;
      wait_idle("retrig");
      check_xfer("retrig", 0);
      act0 = act_cnt;
      CPU_ADDR = 16'h4015; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'h05;
      tick();
      CPU_ADDR = 16'h4014; CPU_RW_n = 1'b1;
      tick();
      CPU_ADDR = 16'h0000;
      repeat (4) tick();
      check("other_addr.no_trig", 64'(act_cnt - act0), 64'd0);

      // RESET at index 100, then restart with page $03 from index 0
      trigger_xfer(8'h02, -1);
      wait_read("rst", 16'h0264);
      RESET = 1'b1;
      #1;
      check("rst.outputs_now", all_outputs(), 64'd0);
      tick();
      RESET = 1'b0;
      tick();
      check("rst.outputs_after", all_outputs(), 64'd0);
      repeat ($urandom_range(1, 6)) tick();
      trigger_xfer(8'h03, -1);
      wait_idle("rst_restart");
      check_xfer("rst_restart", 0);

      // Page $FF with a 10-cycle ENABLE-low stall at a random read index
      repeat ($urandom_range(1, 6)) tick();
      k = $urandom_range(10, 200);
      trigger_xfer(8'hFF, -1);
      wait_read("ff", {8'hFF, 8'(k)});
      ENABLE = 1'b0;
      #1;
      frz_bad = 0;
      repeat (10) begin
         if (DMA_ADDR !== {8'hFF, 8'(k)} || DMA_rden || DMA_write || !DMA_active || !DMA_BUS_REQ)
            frz_bad++;
         tick();
      end
      ENABLE = 1'b1;
      check("ff.stall_frozen", 64'(frz_bad), 64'd0);
      wait_idle("ff");
      check_xfer("ff", 10);
      check("ff.idle_addr", 64'(DMA_ADDR), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
